// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES job sequencer: FSM states, key-length
// codes, round/size constants and the keylen decode helper.
package aes_seq_pkg;

  localparam int BLK_W  = 128;
  localparam int WORD_W = 32;
  localparam int BUF_W  = BLK_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_KEY,
    ST_ISSUE,
    ST_WAIT_ENG,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] KEYLEN_128 = 2'd0;
  localparam logic [1:0] KEYLEN_192 = 2'd1;
  localparam logic [1:0] KEYLEN_256 = 2'd2;

  localparam logic [3:0] ROUNDS_128 = 4'd10;
  localparam logic [3:0] ROUNDS_192 = 4'd12;
  localparam logic [3:0] ROUNDS_256 = 4'd14;
  localparam logic [3:0] SIZE_128   = 4'd4;
  localparam logic [3:0] SIZE_192   = 4'd6;
  localparam logic [3:0] SIZE_256   = 4'd8;

  typedef struct packed {
    logic [3:0] round;
    logic [3:0] size;
  } key_cfg_t;

  function automatic key_cfg_t keylen_cfg(input logic [1:0] keylen);
    key_cfg_t cfg;
    case (keylen)
      KEYLEN_128: cfg = '{round: ROUNDS_128, size: SIZE_128};
      KEYLEN_192: cfg = '{round: ROUNDS_192, size: SIZE_192};
      KEYLEN_256: cfg = '{round: ROUNDS_256, size: SIZE_256};
      default:    cfg = '0;
    endcase
    return cfg;
  endfunction

  function automatic logic keylen_legal(input logic [1:0] keylen);
    return keylen != 2'd3;
  endfunction

endpackage

// File: rtl/aes_job_sequencer_if.sv
// Bus bundle between the DMA/CSR side, the sequencer and the AES engine.
// master = the sequencer, slave = the surrounding environment.
interface aes_job_sequencer_if;
  import aes_seq_pkg::*;

  logic              iCmd_valid;
  logic              oCmd_ready;
  logic              iCmd_endec;
  logic [1:0]        iCmd_keylen;
  logic              iKey_ready;
  logic              iBlk_valid;
  logic              oBlk_ready;
  logic [BLK_W-1:0]  iBlk_data;
  logic              iBlk_last;
  logic              oParam_load;
  logic              oEndec;
  logic [3:0]        oRound;
  logic [3:0]        oSize;
  logic              oData_valid;
  logic [WORD_W-1:0] oData_1, oData_2, oData_3, oData_4;
  logic              iEng_valid;
  logic [WORD_W-1:0] iEng_data_1, iEng_data_2, iEng_data_3, iEng_data_4;
  logic              oOut_valid;
  logic              iOut_ready;
  logic [BLK_W-1:0]  oOut_data;
  logic              oOut_last;
  logic              oBusy;
  logic [1:0]        oErr;

  modport master (
    input  iCmd_valid, iCmd_endec, iCmd_keylen, iKey_ready,
    input  iBlk_valid, iBlk_data, iBlk_last,
    input  iEng_valid, iEng_data_1, iEng_data_2, iEng_data_3, iEng_data_4,
    input  iOut_ready,
    output oCmd_ready, oBlk_ready, oParam_load, oEndec, oRound, oSize,
    output oData_valid, oData_1, oData_2, oData_3, oData_4,
    output oOut_valid, oOut_data, oOut_last, oBusy, oErr
  );

  modport slave (
    output iCmd_valid, iCmd_endec, iCmd_keylen, iKey_ready,
    output iBlk_valid, iBlk_data, iBlk_last,
    output iEng_valid, iEng_data_1, iEng_data_2, iEng_data_3, iEng_data_4,
    output iOut_ready,
    input  oCmd_ready, oBlk_ready, oParam_load, oEndec, oRound, oSize,
    input  oData_valid, oData_1, oData_2, oData_3, oData_4,
    input  oOut_valid, oOut_data, oOut_last, oBusy, oErr
  );

endinterface

// File: rtl/aes_seq_outbuf.sv
// Single-entry valid/ready holding register for engine results (data + last).
// A load in the same cycle as a pop wins; flush drops the entry.
module aes_seq_outbuf
  import aes_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             flush,
  input  logic             pop_ready,
  input  logic [BUF_W-1:0] din,
  output logic             valid,
  output logic [BUF_W-1:0] dout
);

  logic             valid_q, valid_d;
  logic [BUF_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (flush || (valid_q && pop_ready)) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/aes_job_sequencer.sv
// Sequences one AES job: parameter load, key wait, block issue/result loop.
// Optional result timeout is built only when AES_SEQ_TIMEOUT_EN is defined.
module aes_job_sequencer
  import aes_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic iClk,
  input  logic iRst_n,
  aes_job_sequencer_if.master bus
);

  if ((1 << CNT_W) <= TIMEOUT_CYC) begin : g_cnt_w_check
    $error("CNT_W too narrow to reach TIMEOUT_CYC");
  end

  state_e           state_q, state_d;
  key_cfg_t         cfg;
  logic             legal;
  logic             endec_q, endec_d;
  logic [3:0]       round_q, round_d, size_q, size_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             dvalid_q, dvalid_d;
  logic             last_pending_q, last_pending_d;
  logic [1:0]       err_q, err_d;
  logic             cmd_ready, blk_ready, param_load, busy;
  logic             cmd_fire, blk_fire, eng_capture, timeout_hit;
  logic             out_valid;
  logic [BUF_W-1:0] out_q;

  assign cfg         = keylen_cfg(bus.iCmd_keylen);
  assign legal       = keylen_legal(bus.iCmd_keylen);
  assign cmd_fire    = cmd_ready && bus.iCmd_valid;
  assign blk_fire    = blk_ready && bus.iBlk_valid;
  assign eng_capture = (state_q == ST_WAIT_ENG) && bus.iEng_valid;

`ifdef AES_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A result arriving on the expiry cycle still counts as on time.
  assign timeout_hit = (state_q == ST_WAIT_ENG) && !bus.iEng_valid &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC));

  always_comb begin
    cnt_d = cnt_q;
    if (blk_fire)                      cnt_d = '0;
    else if (state_q == ST_WAIT_ENG)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (cmd_fire && legal) state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_WAIT_KEY;
      ST_WAIT_KEY: if (bus.iKey_ready) state_d = ST_ISSUE;
      ST_ISSUE:    if (blk_fire) state_d = ST_WAIT_ENG;
      ST_WAIT_ENG: begin
        if (eng_capture)      state_d = last_pending_q ? ST_DRAIN : ST_ISSUE;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_DRAIN:    if (out_valid && bus.iOut_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == ST_IDLE);
    param_load = (state_q == ST_LOAD);
    busy       = (state_q != ST_IDLE);
    blk_ready  = (state_q == ST_ISSUE) && (!out_valid || bus.iOut_ready);
  end

  always_comb begin
    endec_d        = endec_q;
    round_d        = round_q;
    size_d         = size_q;
    blk_d          = blk_q;
    last_pending_d = last_pending_q;
    dvalid_d       = blk_fire;
    err_d          = err_q;
    if (cmd_fire && legal) begin
      endec_d = bus.iCmd_endec;
      round_d = cfg.round;
      size_d  = cfg.size;
    end
    if (blk_fire) begin
      blk_d          = bus.iBlk_data;
      last_pending_d = bus.iBlk_last;
    end
    // Errors restart with each command; a rejected keylen re-flags bit 0.
    if (cmd_fire) err_d = {1'b0, !legal};
    if (bus.iEng_valid && (state_q != ST_WAIT_ENG)) err_d[0] = 1'b1;
    if (timeout_hit) err_d[1] = 1'b1;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      endec_q        <= 1'b0;
      round_q        <= '0;
      size_q         <= '0;
      blk_q          <= '0;
      last_pending_q <= 1'b0;
      dvalid_q       <= 1'b0;
      err_q          <= '0;
    end else begin
      endec_q        <= endec_d;
      round_q        <= round_d;
      size_q         <= size_d;
      blk_q          <= blk_d;
      last_pending_q <= last_pending_d;
      dvalid_q       <= dvalid_d;
      err_q          <= err_d;
    end
  end

  aes_seq_outbuf u_outbuf (
    .clk       (iClk),
    .rst_n     (iRst_n),
    .load      (eng_capture),
    .flush     (timeout_hit),
    .pop_ready (bus.iOut_ready),
    .din       ({last_pending_q, bus.iEng_data_1, bus.iEng_data_2,
                 bus.iEng_data_3, bus.iEng_data_4}),
    .valid     (out_valid),
    .dout      (out_q)
  );

  assign bus.oCmd_ready  = cmd_ready;
  assign bus.oBlk_ready  = blk_ready;
  assign bus.oParam_load = param_load;
  assign bus.oBusy       = busy;
  assign bus.oEndec      = endec_q;
  assign bus.oRound      = round_q;
  assign bus.oSize       = size_q;
  assign bus.oData_valid = dvalid_q;
  assign bus.oData_1     = blk_q[127:96];
  assign bus.oData_2     = blk_q[95:64];
  assign bus.oData_3     = blk_q[63:32];
  assign bus.oData_4     = blk_q[31:0];
  assign bus.oOut_valid  = out_valid;
  assign bus.oOut_data   = out_q[BLK_W-1:0];
  assign bus.oOut_last   = out_q[BLK_W];
  assign bus.oErr        = err_q;

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Scoreboard bench for aes_job_sequencer: random jobs, a behavioural engine,
// and directed reset / backpressure / error scenarios.
module tb_aes_job_sequencer;

  logic iClk = 1'b0;
  logic iRst_n;
  always #5 iClk = ~iClk;

  aes_job_sequencer_if bus ();

  aes_job_sequencer #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [128:0] exp_q[$];
  logic [127:0] blk_exp_q[$];
  int           loads = 0;
  int           dv_count = 0;
  logic         exp_endec = 1'b0;
  logic [3:0]   exp_round = '0;
  logic [3:0]   exp_size = '0;

  int           eng_cnt = -1;
  logic [127:0] eng_resp = '0;
  bit           eng_auto = 1'b1;
  bit           stray_req = 1'b0;
  int           ready_mode = 0;

  bit           hold_prev = 1'b0;
  logic [129:0] prev_out = '0;
  logic [128:0] mon_e;
  logic [127:0] mon_b;

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Stand-in for the AES engine: a known-answer vector plus a fixed scramble.
  function automatic logic [127:0] eng_f(input logic [127:0] b);
    if (b == 128'h00112233_44556677_8899aabb_ccddeeff)
      return 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    return {b[63:0], ~b[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
  endfunction

  always @(negedge iClk) begin
    if (iRst_n && bus.oData_valid) begin
      dv_count++;
      if (blk_exp_q.size() == 0) fail("eng_unexpected_block");
      else begin
        mon_b = blk_exp_q.pop_front();
        check("eng_word1", 130'(bus.oData_1), 130'(mon_b[127:96]));
        check("eng_block", 130'({bus.oData_1, bus.oData_2, bus.oData_3, bus.oData_4}), 130'(mon_b));
      end
      if (eng_auto) begin
        eng_resp = eng_f({bus.oData_1, bus.oData_2, bus.oData_3, bus.oData_4});
        eng_cnt  = $urandom_range(0, 4);
      end
    end
  end

  always @(posedge iClk) begin
    #1;
    if (eng_cnt == 0) begin
      bus.iEng_valid = 1'b1;
      {bus.iEng_data_1, bus.iEng_data_2, bus.iEng_data_3, bus.iEng_data_4} = eng_resp;
      eng_cnt = -1;
    end else begin
      bus.iEng_valid = stray_req;
      if (eng_cnt > 0) eng_cnt--;
    end
  end

  always @(posedge iClk) begin
    #1;
    case (ready_mode)
      0:       bus.iOut_ready = ($urandom_range(0, 3) != 0);
      1:       bus.iOut_ready = 1'b0;
      default: bus.iOut_ready = 1'b1;
    endcase
  end

  always @(negedge iClk) begin
    if (!iRst_n) hold_prev = 1'b0;
    else begin
      if (hold_prev)
        check("out_stable", {bus.oOut_valid, bus.oOut_last, bus.oOut_data}, prev_out);
      if (bus.oOut_valid && bus.iOut_ready) begin
        if (exp_q.size() == 0) fail("out_unexpected");
        else begin
          mon_e = exp_q.pop_front();
          check("out_data", 130'(bus.oOut_data), 130'(mon_e[127:0]));
          check("out_last", 130'(bus.oOut_last), 130'(mon_e[128]));
        end
      end
      hold_prev = bus.oOut_valid && !bus.iOut_ready;
      prev_out  = {bus.oOut_valid, bus.oOut_last, bus.oOut_data};
    end
  end

  always @(negedge iClk) begin
    if (iRst_n && bus.oParam_load) begin
      loads++;
      check("param_round", 130'(bus.oRound), 130'(exp_round));
      check("param_size", 130'(bus.oSize), 130'(exp_size));
      check("param_endec", 130'(bus.oEndec), 130'(exp_endec));
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge iClk);
    while (bus.oBusy !== 1'b0 && n < 1000) begin
      @(negedge iClk);
      n++;
    end
    if (bus.oBusy !== 1'b0) fail(name);
  endtask

  task automatic send_cmd(input logic endec, input logic [1:0] keylen, input logic key_rdy);
    @(posedge iClk);
    #1;
    bus.iCmd_valid  = 1'b1;
    bus.iCmd_endec  = endec;
    bus.iCmd_keylen = keylen;
    bus.iKey_ready  = key_rdy;
    if (keylen != 2'd3) begin
      exp_endec = endec;
      exp_round = 4'(10 + 2 * int'(keylen));
      exp_size  = 4'(4 + 2 * int'(keylen));
    end
    @(posedge iClk);
    #1;
    bus.iCmd_valid = 1'b0;
  endtask

  task automatic present_blk(input logic [127:0] d, input logic last);
    bus.iBlk_valid = 1'b1;
    bus.iBlk_data  = d;
    bus.iBlk_last  = last;
    blk_exp_q.push_back(d);
    exp_q.push_back({last, eng_f(d)});
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    @(negedge iClk);
    while (!bus.oBlk_ready && n < 1000) begin
      @(negedge iClk);
      n++;
    end
    if (!bus.oBlk_ready) fail(name);
    @(posedge iClk);
    #1;
    bus.iBlk_valid = 1'b0;
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_job(input logic endec, input logic [1:0] keylen, input int nblk,
                         input int key_delay, input logic [127:0] first_blk, input bit use_first);
    int l0, dv0, gap;
    logic [127:0] d;
    l0 = loads;
    send_cmd(endec, keylen, key_delay == 0);
    for (int i = 0; i < nblk; i++) begin
      d = (i == 0 && use_first) ? first_blk : rand_blk();
      present_blk(d, i == nblk - 1);
      if (i == 0 && key_delay > 0) begin
        dv0 = dv_count;
        repeat (key_delay) @(posedge iClk);
        check("no_issue_before_key", 130'(dv_count), 130'(dv0));
        #1;
        bus.iKey_ready = 1'b1;
      end
      wait_accept("blk_accept");
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge iClk);
        #1;
      end
    end
    wait_idle("job_done");
    check("param_load_once", 130'(loads - l0), 130'd1);
    check("out_all_returned", 130'(exp_q.size()), 130'd0);
    check("err_clear", 130'(bus.oErr), 130'd0);
  endtask

  task automatic backpressure_job();
    int l0, n;
    l0 = loads;
    @(negedge iClk);
    ready_mode = 1;
    send_cmd(1'b0, 2'd1, 1'b1);
    present_blk(rand_blk(), 1'b0);
    wait_accept("bp_blk0");
    present_blk(rand_blk(), 1'b0);
    n = 0;
    @(negedge iClk);
    while (!bus.oOut_valid && n < 100) begin
      @(negedge iClk);
      n++;
    end
    if (!bus.oOut_valid) fail("bp_first_result");
    repeat (10) begin
      check("bp_blk_ready_low", 130'(bus.oBlk_ready), 130'd0);
      check("bp_out_held", 130'(bus.oOut_valid), 130'd1);
      @(negedge iClk);
    end
    ready_mode = 2;
    @(negedge iClk);
    check("bp_drain_and_issue", 130'({bus.oOut_valid, bus.iOut_ready, bus.oBlk_ready}), 130'b111);
    @(posedge iClk);
    #1;
    bus.iBlk_valid = 1'b0;
    present_blk(rand_blk(), 1'b1);
    wait_accept("bp_blk2");
    @(negedge iClk);
    ready_mode = 0;
    wait_idle("bp_done");
    check("bp_param_load_once", 130'(loads - l0), 130'd1);
    check("bp_all_returned", 130'(exp_q.size()), 130'd0);
  endtask

  task automatic reset_test();
    eng_auto = 1'b0;
    send_cmd(1'b1, 2'd1, 1'b1);
    present_blk(rand_blk(), 1'b1);
    wait_accept("rst_blk");
    repeat (3) @(negedge iClk);
    check("rst_pre_busy", 130'(bus.oBusy), 130'd1);
    #2;
    iRst_n = 1'b0;
    #1;
    check("rst_ctrl", 130'({bus.oBusy, bus.oData_valid, bus.oOut_valid, bus.oParam_load,
                            bus.oBlk_ready, bus.oEndec, bus.oErr, bus.oOut_last}), 130'd0);
    check("rst_cfg", 130'({bus.oRound, bus.oSize}), 130'd0);
    check("rst_data", 130'({bus.oData_1, bus.oData_2, bus.oData_3, bus.oData_4}), 130'd0);
    check("rst_out", 130'(bus.oOut_data), 130'd0);
    exp_q.delete();
    blk_exp_q.delete();
    @(posedge iClk);
    @(posedge iClk);
    #1;
    iRst_n   = 1'b1;
    eng_auto = 1'b1;
    run_job(1'b0, 2'd0, 1, 0, '0, 1'b0);
  endtask

`ifdef AES_SEQ_TIMEOUT_EN
  task automatic timeout_test();
    int n;
    eng_auto = 1'b0;
    send_cmd(1'b0, 2'd0, 1'b1);
    present_blk(rand_blk(), 1'b1);
    wait_accept("to_blk");
    n = 0;
    @(negedge iClk);
    while (!bus.oData_valid && n < 20) begin
      @(negedge iClk);
      n++;
    end
    n = 0;
    while (!bus.oErr[1] && n < 200) begin
      @(negedge iClk);
      n++;
    end
    check("timeout_cycles", 130'(n), 130'd64);
    check("timeout_idle", 130'({bus.oBusy, bus.oOut_valid}), 130'd0);
    exp_q.delete();
    eng_auto = 1'b1;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, nb, kd;
    logic [1:0] kl;
    iRst_n          = 1'b0;
    bus.iCmd_valid  = 1'b0;
    bus.iCmd_endec  = 1'b0;
    bus.iCmd_keylen = 2'd0;
    bus.iKey_ready  = 1'b0;
    bus.iBlk_valid  = 1'b0;
    bus.iBlk_data   = '0;
    bus.iBlk_last   = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    check("reset_ctrl", 130'({bus.oBusy, bus.oData_valid, bus.oOut_valid, bus.oParam_load,
                              bus.oBlk_ready, bus.oErr}), 130'd0);
    check("reset_cfg", 130'({bus.oEndec, bus.oRound, bus.oSize}), 130'd0);
    iRst_n = 1'b1;

    run_job(1'b0, 2'd0, 1, 0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
    check("kat_cfg", 130'({bus.oEndec, bus.oRound, bus.oSize}), 130'({1'b0, 4'd10, 4'd4}));

    run_job(1'b1, 2'd2, 2, 5, '0, 1'b0);
    check("dec256_cfg", 130'({bus.oEndec, bus.oRound, bus.oSize}), 130'({1'b1, 4'd14, 4'd8}));

    backpressure_job();

    l0 = loads;
    send_cmd(1'b0, 2'd3, 1'b1);
    @(negedge iClk);
    check("illegal_err", 130'(bus.oErr), 130'b01);
    check("illegal_busy", 130'(bus.oBusy), 130'd0);
    repeat (3) @(negedge iClk);
    check("illegal_no_load", 130'({loads - l0, bus.oBusy}), 130'd0);

    run_job(1'b1, 2'd0, 1, 0, '0, 1'b0);
    @(negedge iClk);
    stray_req = 1'b1;
    @(negedge iClk);
    stray_req = 1'b0;
    @(negedge iClk);
    check("stray_err", 130'(bus.oErr), 130'b01);
    check("stray_busy", 130'(bus.oBusy), 130'd0);

    for (int j = 0; j < 8; j++) begin
      kl = 2'($urandom_range(0, 2));
      nb = $urandom_range(1, 4);
      kd = $urandom_range(0, 3);
      run_job(1'($urandom_range(0, 1)), kl, nb, kd, '0, 1'b0);
    end

    reset_test();
`ifdef AES_SEQ_TIMEOUT_EN
    timeout_test();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
